sd_dma_writer: RTL and testbench

//   Downstream stage of the SD SPI interface. Buffers 32-bit words that the SD receive path

---
 rtl/sd_dma_writer_if.sv | 21 ++
 rtl/sd_dma_writer.sv | 102 ++++++++++
 tb/tb_sd_dma_writer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sd_dma_writer_if.sv
// rtl/sd_dma_writer_if.sv - SDRAM bus master port of the SD DMA writer
interface sd_dma_writer_if;
  logic        o_request;
  logic        o_write;
  logic        i_busy;
  logic        i_ack;
  logic [3:0]  o_bank;
  logic [23:0] o_address;
  logic [31:0] o_data;
  logic [31:0] i_data;

  modport master (
    output o_request, o_write, o_bank, o_address, o_data,
    input  i_busy, i_ack, i_data
  );

  modport slave (
    input  o_request, o_write, o_bank, o_address, o_data,
    output i_busy, i_ack, i_data
  );
endinterface

// File: rtl/sd_dma_writer.sv
// rtl/sd_dma_writer.sv - FIFO-buffered word writer from the SD receive path into SDRAM
// Words pushed by the SPI side drain to consecutive word addresses once a run is started.
module sd_dma_writer #(
  parameter int DEPTH_LOG2  = 3,
  parameter int FULL_MARGIN = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_fifo_flush,
  input  logic        i_fifo_push,
  input  logic [31:0] i_fifo_data,
  output logic        o_fifo_full,
  output logic        o_fifo_empty,
  output logic        o_overflow,
  input  logic        i_start,
  input  logic [23:0] i_start_address,
  output logic        o_running,
  sd_dma_writer_if.master bus
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam int         CW       = DEPTH_LOG2 + 1;
  localparam logic [3:0] BANK_ROM = 4'h0;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_next;
  logic [31:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]           count, avail;
  logic                    pop, push_ok, push_drop;
  logic                    request;
  logic [23:0]             address;
  logic                    unused_inputs;

  assign unused_inputs = ^{bus.i_ack, bus.i_data};

  // A pop is always paired with a bus accept; flush suppresses it even though the bus completes.
  assign pop       = request && !bus.i_busy && !i_fifo_flush;
  assign push_ok   = i_fifo_push && !i_fifo_flush && (count != CW'(DEPTH) || pop);
  assign push_drop = i_fifo_push && !i_fifo_flush && count == CW'(DEPTH) && !pop;
  assign avail     = count - CW'(pop);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i_fifo_flush) state_next = IDLE;
    else if (i_start) state_next = RUN;
  end

  always_comb begin
    o_running    = (state == RUN);
    o_fifo_empty = (count == '0);
    o_fifo_full  = (count >= CW'(DEPTH - FULL_MARGIN));
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_fifo_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else if (i_fifo_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok)   wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      if (push_drop) o_overflow <= 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // Request looks at words remaining after this cycle's pop, so it never outlives the last word.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      request <= 1'b0;
      address <= '0;
    end else if (i_fifo_flush) begin
      request <= 1'b0;
    end else begin
      request <= (state_next == RUN) && (avail != '0);
      if (i_start)  address <= i_start_address;
      else if (pop) address <= address + 24'd1;
    end
  end

  assign bus.o_request = request;
  assign bus.o_write   = 1'b1;
  assign bus.o_bank    = BANK_ROM;
  assign bus.o_address = address;
  assign bus.o_data    = mem[rd_ptr];
endmodule

// File: tb/tb_sd_dma_writer.sv
// tb/tb_sd_dma_writer.sv - directed self-checking bench for sd_dma_writer
module tb_sd_dma_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, push = 1'b0, start = 1'b0;
  logic [31:0] fdata = '0;
  logic [23:0] saddr = '0;
  logic        full, empty, overflow, running;
  int          passed = 0, total = 0;
  logic [23:0] wa[$];
  logic [31:0] wd[$];

  sd_dma_writer_if bus ();

  sd_dma_writer #(.DEPTH_LOG2(3), .FULL_MARGIN(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_fifo_flush(flush), .i_fifo_push(push),
    .i_fifo_data(fdata), .o_fifo_full(full), .o_fifo_empty(empty), .o_overflow(overflow),
    .i_start(start), .i_start_address(saddr), .o_running(running), .bus(bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_request && !bus.i_busy) begin
      wa.push_back(bus.o_address);
      wd.push_back(bus.o_data);
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_word(logic [31:0] d);
    push = 1'b1; fdata = d; tick(1); push = 1'b0;
  endtask

  task automatic start_at(logic [23:0] a);
    start = 1'b1; saddr = a; tick(1); start = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(1); flush = 1'b0;
  endtask

  task automatic wait_writes(int n, int budget);
    int c = 0;
    while (wa.size() < n && c < budget) begin tick(1); c++; end
    total++;
    if (wa.size() < n) $display("FAIL wait_writes got %0d writes need %0d", wa.size(), n);
    else passed++;
  endtask

  task automatic test_reset();
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else passed++;
    total++; if (running !== 1'b0) $display("FAIL reset_running got %b exp 0", running); else passed++;
    total++; if (bus.o_request !== 1'b0) $display("FAIL reset_request got %b exp 0", bus.o_request); else passed++;
    total++; if (bus.o_address !== 24'h0) $display("FAIL reset_address got %h exp 000000", bus.o_address); else passed++;
    total++; if (bus.o_write !== 1'b1) $display("FAIL write_const got %b exp 1", bus.o_write); else passed++;
  endtask

  task automatic test_basic();
    wa.delete(); wd.delete(); bus.i_busy = 1'b0;
    start_at(24'h000100);
    total++; if (running !== 1'b1) $display("FAIL basic_running got %b exp 1", running); else passed++;
    push_word(32'h11223344);
    push_word(32'h55667788);
    wait_writes(2, 20);
    tick(3);
    total++; if (wa.size() !== 2) $display("FAIL basic_count got %0d exp 2", wa.size()); else passed++;
    total++; if (wa[0] !== 24'h000100 || wd[0] !== 32'h11223344)
      $display("FAIL basic_w0 got %h/%h exp 000100/11223344", wa[0], wd[0]); else passed++;
    total++; if (wa[1] !== 24'h000101 || wd[1] !== 32'h55667788)
      $display("FAIL basic_w1 got %h/%h exp 000101/55667788", wa[1], wd[1]); else passed++;
    total++; if (empty !== 1'b1 || bus.o_request !== 1'b0)
      $display("FAIL basic_idle_bus got empty=%b req=%b exp 1/0", empty, bus.o_request); else passed++;
    do_flush();
  endtask

  task automatic test_overflow();
    int bad = 0;
    wa.delete(); wd.delete(); bus.i_busy = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'hA000_0000 + i);
    total++; if (full !== 1'b0) $display("FAIL full_at6 got %b exp 0", full); else passed++;
    push_word(32'hA000_0006);
    total++; if (full !== 1'b1) $display("FAIL full_at7 got %b exp 1", full); else passed++;
    push_word(32'hA000_0007);
    total++; if (overflow !== 1'b0) $display("FAIL ovf_at8 got %b exp 0", overflow); else passed++;
    push_word(32'hA000_0008);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_at9 got %b exp 1", overflow); else passed++;
    total++; if (wa.size() !== 0) $display("FAIL idle_no_write got %0d exp 0", wa.size()); else passed++;
    start_at(24'h000200);
    wait_writes(8, 12);
    tick(4);
    total++; if (wa.size() !== 8) $display("FAIL burst_count got %0d exp 8", wa.size()); else passed++;
    for (int i = 0; i < 8 && i < wa.size(); i++)
      if (wa[i] !== 24'h000200 + i || wd[i] !== 32'hA000_0000 + i) bad++;
    total++; if (bad !== 0) $display("FAIL burst_data got %0d bad words exp 0", bad); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else passed++;
    do_flush();
    total++; if (overflow !== 1'b0) $display("FAIL ovf_flush got %b exp 0", overflow); else passed++;
  endtask

  task automatic test_busy();
    logic [23:0] a0;
    logic [31:0] d0;
    int moved = 0;
    wa.delete(); wd.delete(); bus.i_busy = 1'b1;
    start_at(24'h000300);
    push_word(32'hCAFEF00D);
    tick(2);
    total++; if (bus.o_request !== 1'b1) $display("FAIL busy_req got %b exp 1", bus.o_request); else passed++;
    a0 = bus.o_address; d0 = bus.o_data;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (bus.o_address !== a0 || bus.o_data !== d0 || bus.o_request !== 1'b1) moved++;
    end
    total++; if (moved !== 0) $display("FAIL busy_stable got %0d changes exp 0", moved); else passed++;
    total++; if (wa.size() !== 0 || empty !== 1'b0)
      $display("FAIL busy_nopop got writes=%0d empty=%b exp 0/0", wa.size(), empty); else passed++;
    bus.i_busy = 1'b0;
    tick(3);
    total++; if (wa.size() !== 1) $display("FAIL busy_release got %0d writes exp 1", wa.size()); else passed++;
    total++; if (wa.size() > 0 && (wa[0] !== 24'h000300 || wd[0] !== 32'hCAFEF00D))
      $display("FAIL busy_word got %h/%h exp 000300/cafef00d", wa[0], wd[0]); else passed++;
    do_flush();
  endtask

  task automatic test_wrap();
    wa.delete(); wd.delete(); bus.i_busy = 1'b0;
    start_at(24'hFFFFFF);
    push_word(32'h0BADF00D);
    push_word(32'h12345678);
    wait_writes(2, 20);
    tick(2);
    total++; if (wa.size() !== 2 || wa[0] !== 24'hFFFFFF || wa[1] !== 24'h000000)
      $display("FAIL wrap_addr got n=%0d %h %h exp FFFFFF 000000", wa.size(), wa[0], wa[1]); else passed++;
    total++; if (bus.o_address !== 24'h000001) $display("FAIL wrap_next got %h exp 000001", bus.o_address); else passed++;
    do_flush();
  endtask

  task automatic test_flush();
    wa.delete(); wd.delete(); bus.i_busy = 1'b1;
    start_at(24'h000500);
    for (int i = 0; i < 3; i++) push_word(32'hF0 + i);
    tick(1);
    total++; if (bus.o_request !== 1'b1) $display("FAIL flush_pre_req got %b exp 1", bus.o_request); else passed++;
    flush = 1'b1; push = 1'b1; fdata = 32'hDEAD0000;
    tick(1);
    flush = 1'b0; push = 1'b0;
    total++; if (empty !== 1'b1 || running !== 1'b0 || overflow !== 1'b0 || bus.o_request !== 1'b0)
      $display("FAIL flush_state got empty=%b run=%b ovf=%b req=%b exp 1/0/0/0",
               empty, running, overflow, bus.o_request); else passed++;
    bus.i_busy = 1'b0;
    tick(5);
    total++; if (wa.size() !== 0) $display("FAIL flush_nowrite got %0d exp 0", wa.size()); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    bus.i_busy = 1'b1;
    start_at(24'h000400);
    push_word(32'h01010101);
    push_word(32'h02020202);
    tick(2);
    total++; if (bus.o_request !== 1'b1) $display("FAIL mid_req got %b exp 1", bus.o_request); else passed++;
    #3 rst_n = 1'b0;
    #1;
    total++; if (bus.o_request !== 1'b0) $display("FAIL async_req got %b exp 0", bus.o_request); else passed++;
    total++; if (empty !== 1'b1 || running !== 1'b0 || bus.o_address !== 24'h0 || overflow !== 1'b0 || full !== 1'b0)
      $display("FAIL async_outputs got empty=%b run=%b addr=%h ovf=%b full=%b exp 1/0/000000/0/0",
               empty, running, bus.o_address, overflow, full); else passed++;
    tick(2);
    rst_n = 1'b1;
    bus.i_busy = 1'b0;
    tick(2);
  endtask

  initial begin
    bus.i_busy = 1'b0; bus.i_ack = 1'b0; bus.i_data = '0;
    #2;
    tick(2);
    test_reset();
    rst_n = 1'b1;
    tick(2);
    test_basic();
    test_overflow();
    test_busy();
    test_wrap();
    test_flush();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
